piso_readout: RTL and testbench

PISO_READOUT -- requirements
Module: piso_readout

---
 rtl/rsnn_pkg.sv | 14 +
 rtl/piso_readout.sv | 107 ++++++++++
 tb/tb_piso_readout.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsnn_pkg.sv
// Shared frame definitions so the FIPO writer and PISO reader agree on frame
// length and readout state encoding.
package rsnn_pkg;

    localparam int FRAME_W     = 312;
    localparam int FRAME_CNT_W = 9;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_SHIFT = 2'd1,
        RD_DONE  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/piso_readout.sv
// Parallel-in serial-out frame reader: captures a word on start and emits it
// LSB first, one bit per enable strobe, with stall, abort and end-of-frame pulse.
module piso_readout
    import rsnn_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    input  logic             abort,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             end_reading,
    output logic [CNT_W-1:0] bit_index
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    rd_state_e        state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             sout_q, sout_d;
    logic             bv_q, bv_d;
    logic             end_q, end_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RD_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            sout_q   <= 1'b0;
            bv_q     <= 1'b0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sout_q   <= sout_d;
            bv_q     <= bv_d;
            end_q    <= end_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sout_d   = sout_q;
        bv_d     = 1'b0;
        end_d    = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            RD_IDLE: begin
                busy_d = 1'b0;
                // abort outranks start even while idle
                if (start && !abort) begin
                    shadow_d = parallel_in;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RD_SHIFT;
                end
            end
            RD_SHIFT: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = RD_IDLE;
                end else if (enable) begin
                    sout_d = shadow_q[cnt_q];
                    idx_d  = cnt_q;
                    bv_d   = 1'b1;
                    // counter parks on the last index instead of wrapping
                    if (cnt_q == LAST_IDX) state_d = RD_DONE;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RD_DONE: begin
                // end_reading lands in the first idle cycle, alongside busy low
                busy_d  = 1'b0;
                end_d   = !abort;
                state_d = RD_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = RD_IDLE;
            end
        endcase
    end

    assign serial_out  = sout_q;
    assign bit_valid   = bv_q;
    assign busy        = busy_q;
    assign end_reading = end_q;
    assign bit_index   = idx_q;

endmodule

// File: tb/tb_piso_readout.sv
// Directed bench for piso_readout: frames, stall, capture isolation, reset,
// abort-vs-start, back-to-back gap and a writer-model round trip.
module tb_piso_readout;

    localparam int W  = 312;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          enable;
    logic          abort;
    logic [W-1:0]  pin;
    logic          serial_out;
    logic          bit_valid;
    logic          busy;
    logic          end_reading;
    logic [CW-1:0] bit_index;

    int total = 0;
    int bad   = 0;

    piso_readout #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .enable      (enable),
        .abort       (abort),
        .parallel_in (pin),
        .serial_out  (serial_out),
        .bit_valid   (bit_valid),
        .busy        (busy),
        .end_reading (end_reading),
        .bit_index   (bit_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive start for one edge; optionally scramble parallel_in right after capture.
    task automatic start_frame(input logic [W-1:0] w, input bit scramble);
        @(negedge clk);
        pin    = w;
        start  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) pin = '1;
        chk("cap_busy", busy, 1'b1);
        chk("cap_bv", bit_valid, 1'b0);
    endtask

    // Watch a frame with enable high; a writer model fills ascending from serial_out.
    task automatic run_frame(input logic [W-1:0] w);
        int n = 0;
        int last = -10;
        bit done = 1'b0;
        logic [W-1:0] wr = '0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (bit_valid) begin
                if (n < W) begin
                    chk("bit", serial_out, w[n]);
                    chk("idx", bit_index, W'(n));
                    wr[n] = serial_out;
                    if (n == W - 1) chk("done_busy", busy, 1'b1);
                end else begin
                    chk("extra_bit", 1'b1, 1'b0);
                end
                last = c;
                n++;
            end
            if (end_reading) begin
                chk("end_gap", W'(c - last), W'(1));
                chk("end_busy", busy, 1'b0);
                done = 1'b1;
            end
        end
        chk("end_seen", done, 1'b1);
        chk("nbits", W'(n), W'(W));
        chk("roundtrip", wr, w);
    endtask

    // Run with enable high until bit_index reaches target; returns whether it did.
    task automatic wait_idx(input int target, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (bit_valid && bit_index == CW'(target)) hit = 1'b1;
        end
        chk("reach_idx", hit, 1'b1);
    endtask

    initial begin
        logic [W-1:0] w0, w1, w2, w3;
        bit hit;
        int cnt;
        int first_gap;
        rst = 1'b1; start = 1'b0; enable = 1'b0; abort = 1'b0; pin = '0;
        w0 = '0; w0[0] = 1'b1; w0[5] = 1'b1; w0[311] = 1'b1;
        w1 = {39{8'hA5}};
        w2 = {78{4'h3}};
        w3 = {39{8'h96}};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_sout", serial_out, 1'b0);
        chk("rst_bv", bit_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_end", end_reading, 1'b0);
        chk("rst_idx", bit_index, '0);
        rst = 1'b0;

        // enable alone in idle emits nothing
        enable = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bit_valid) cnt++;
        end
        chk("idle_no_bv", W'(cnt), '0);
        enable = 1'b0;

        // basic frame, bits 0/5/311
        start_frame(w0, 1'b0);
        run_frame(w0);

        // capture isolation: parallel_in goes all-ones after capture
        start_frame(w1, 1'b1);
        run_frame(w1);

        // stall: enable 1,0,0,1 ; word bit0=1 bit1=0
        @(negedge clk);
        pin = W'(1); start = 1'b1; enable = 1'b0;
        @(negedge clk);
        start = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("st0_bv", bit_valid, 1'b1); chk("st0_idx", bit_index, '0); chk("st0_so", serial_out, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("st1_bv", bit_valid, 1'b0); chk("st1_idx", bit_index, '0); chk("st1_so", serial_out, 1'b1);
        @(negedge clk);
        chk("st2_bv", bit_valid, 1'b0); chk("st2_idx", bit_index, '0); chk("st2_so", serial_out, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        chk("st3_bv", bit_valid, 1'b1); chk("st3_idx", bit_index, W'(1)); chk("st3_so", serial_out, 1'b0);
        // abort the stalled frame
        enable = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_bv", bit_valid, 1'b0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (end_reading || bit_valid) cnt++;
        end
        chk("ab_quiet", W'(cnt), '0);

        // mid-frame reset at bit_index 100
        start_frame(w2, 1'b0);
        wait_idx(100, hit);
        rst = 1'b1;
        #1;
        chk("mrst_sout", serial_out, 1'b0);
        chk("mrst_bv", bit_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_end", end_reading, 1'b0);
        chk("mrst_idx", bit_index, '0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bit_valid || busy) cnt++;
        end
        chk("mrst_no_bv", W'(cnt), '0);

        // abort and start together at bit_index 50
        start_frame(w1, 1'b0);
        wait_idx(50, hit);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("avs_busy", busy, 1'b0);
        chk("avs_bv", bit_valid, 1'b0);
        chk("avs_end", end_reading, 1'b0);
        pin = w3;
        @(negedge clk);
        start = 1'b0;
        chk("avs_cap", busy, 1'b1);
        run_frame(w3);

        // start held high: back-to-back frames, gap of 2 idle cycles between bits
        @(negedge clk);
        pin = w0; start = 1'b1; enable = 1'b1;
        cnt = 0; first_gap = -1; hit = 1'b0;
        for (int c = 0; c < 700 && first_gap < 0; c++) begin
            @(negedge clk);
            if (bit_valid) begin
                if (hit) begin
                    first_gap = c - cnt;
                    chk("b2b_idx", bit_index, '0);
                    chk("b2b_so", serial_out, w0[0]);
                end
                cnt = c;
            end
            if (end_reading) hit = 1'b1;
        end
        chk("b2b_gap", W'(first_gap), W'(3));
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; enable = 1'b0;
        chk("b2b_abort", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
